// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the pipeline sequencer: state encoding,
// default interrupt vector and the {fetch, dcd, exe} enable patterns.
package pipe_seq_pkg;

  localparam int unsigned EN_W = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    VECTOR = 2'd2,
    ISR    = 2'd3
  } state_e;

  localparam logic [15:0] INT_VECTOR_DEFAULT = 16'h0010;

  localparam logic [EN_W-1:0] EN_ALL   = 3'b111;
  localparam logic [EN_W-1:0] EN_DRAIN = 3'b011;
  localparam logic [EN_W-1:0] EN_VEC   = 3'b100;

  // Stage enable pattern for each state, ordered {fetch, dcd, exe}.
  function automatic logic [EN_W-1:0] state_enables(input state_e st);
    logic [EN_W-1:0] en;
    case (st)
      FLUSH:   en = EN_DRAIN;
      VECTOR:  en = EN_VEC;
      default: en = EN_ALL;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/int_edge_latch.sv
// Interrupt rising-edge detector with mask qualification and a single pending flag.
// A new edge wins over a same-cycle clear so a fresh request is never dropped.
module int_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic interrupt,
  input  logic int_mask,
  input  logic clear,
  output logic pending
);

  logic int_prev;
  logic edge_c;

  assign edge_c = interrupt & ~int_prev & ~int_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      int_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      int_prev <= interrupt;
      if (edge_c) begin
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: stage enables with stall handling, and interrupt entry
// (drain, vector load, in-ISR tracking, RTI return).
module pipe_seq_ctrl
  import pipe_seq_pkg::*;
#(
  parameter int unsigned             PIPE_DEPTH = 3,
  parameter int unsigned             PMA_SIZE   = 16,
  parameter logic [PMA_SIZE-1:0]     INT_VECTOR = PMA_SIZE'(INT_VECTOR_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                interrupt,
  input  logic                stallb_en,
  input  logic                int_mask,
  input  logic                ps_rti,
  output logic                fetch_en,
  output logic                dcd_en,
  output logic                exe_en,
  output logic                ps_int_vec_ld,
  output logic [PMA_SIZE-1:0] int_vec,
  output logic                ps_int_ack,
  output logic                in_isr
);

  localparam int unsigned       CNT_W      = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(PIPE_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  if (PIPE_DEPTH < 2) begin : g_depth_check
    $error("pipe_seq_ctrl: PIPE_DEPTH must be at least 2");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending;
  logic              clr_pend;
  logic [EN_W-1:0]   en_d;
  logic              vec_d;
  logic              isr_d;

  int_edge_latch u_int_edge_latch (
    .clk       (clk),
    .reset     (reset),
    .interrupt (interrupt),
    .int_mask  (int_mask),
    .clear     (clr_pend),
    .pending   (pending)
  );

  assign int_vec = INT_VECTOR;

  // State, drain counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      fetch_en      <= 1'b0;
      dcd_en        <= 1'b0;
      exe_en        <= 1'b0;
      ps_int_vec_ld <= 1'b0;
      ps_int_ack    <= 1'b0;
      in_isr        <= 1'b0;
    end else begin
      state_q                   <= state_d;
      cnt_q                     <= cnt_d;
      {fetch_en, dcd_en, exe_en} <= en_d;
      ps_int_vec_ld             <= vec_d;
      ps_int_ack                <= vec_d;
      in_isr                    <= isr_d;
    end
  end

  // Next state and next outputs; a stall freezes everything but edge capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_pend = 1'b0;
    en_d     = '0;
    vec_d    = 1'b0;
    isr_d    = 1'b0;

    if (stallb_en) begin
      case (state_q)
        RUN: begin
          if (pending) begin
            state_d = FLUSH;
            cnt_d   = DRAIN_LOAD;
          end
        end
        FLUSH: begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d  = VECTOR;
            clr_pend = 1'b1;
          end
        end
        VECTOR: begin
          state_d = ISR;
        end
        ISR: begin
          if (ps_rti) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    // VECTOR is only reachable unstalled from FLUSH, so this fires once per entry.
    if (stallb_en) begin
      en_d  = state_enables(state_d);
      vec_d = (state_d == VECTOR);
    end
    isr_d = (state_d == ISR);
  end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: vector table, directed multi-cycle sequences and
// randomized stimulus checked against a behavioural sequencing model.
module tb_pipe_seq_ctrl;

  localparam int unsigned PIPE_DEPTH = 3;
  localparam int unsigned PMA_SIZE   = 16;

  logic clk = 1'b0;
  logic reset, interrupt, stallb_en, int_mask, ps_rti;
  logic fetch_en, dcd_en, exe_en, ps_int_vec_ld, ps_int_ack, in_isr;
  logic [PMA_SIZE-1:0] int_vec;
  logic [5:0] outs;

  assign outs = {fetch_en, dcd_en, exe_en, ps_int_vec_ld, ps_int_ack, in_isr};

  always #5 clk = ~clk;

  pipe_seq_ctrl #(.PIPE_DEPTH(PIPE_DEPTH), .PMA_SIZE(PMA_SIZE), .INT_VECTOR(16'h0010)) dut (
    .clk           (clk),
    .reset         (reset),
    .interrupt     (interrupt),
    .stallb_en     (stallb_en),
    .int_mask      (int_mask),
    .ps_rti        (ps_rti),
    .fetch_en      (fetch_en),
    .dcd_en        (dcd_en),
    .exe_en        (exe_en),
    .ps_int_vec_ld (ps_int_vec_ld),
    .int_vec       (int_vec),
    .ps_int_ack    (ps_int_ack),
    .in_isr        (in_isr)
  );

  typedef struct packed {
    logic       rst;
    logic       intr;
    logic       stb;
    logic       msk;
    logic       rti;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [18];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: remaining drain cycles, vector-load phase, ISR flag, pending.
  int         m_drain;
  logic       m_vec, m_isr, m_pend, m_prev;
  logic [5:0] m_out;

  function automatic vec_t mk(input logic r, input logic i, input logic s,
                              input logic m, input logic t, input logic [5:0] e);
    vec_t v;
    v.rst = r; v.intr = i; v.stb = s; v.msk = m; v.rti = t; v.exp = e;
    return v;
  endfunction

  task automatic model_step();
    logic set_p, clr_p, old_p;
    set_p = interrupt && !m_prev && !int_mask;
    if (reset) begin
      m_drain = 0; m_vec = 1'b0; m_isr = 1'b0; m_pend = 1'b0; m_prev = 1'b0;
      m_out = 6'b000000;
    end else begin
      old_p = m_pend;
      clr_p = 1'b0;
      if (stallb_en) begin
        if (m_vec) begin
          m_vec = 1'b0;
          m_isr = 1'b1;
        end else if (m_drain > 0) begin
          m_drain = m_drain - 1;
          if (m_drain == 0) begin
            m_vec = 1'b1;
            clr_p = 1'b1;
          end
        end else if (m_isr) begin
          if (ps_rti) m_isr = 1'b0;
        end else if (old_p) begin
          m_drain = PIPE_DEPTH - 1;
        end
      end
      m_pend = set_p | (old_p & ~clr_p);
      m_prev = interrupt;
      m_out[5]   = stallb_en && (m_drain == 0);
      m_out[4]   = stallb_en && !m_vec;
      m_out[3]   = stallb_en && !m_vec;
      m_out[2]   = stallb_en && m_vec;
      m_out[1]   = stallb_en && m_vec;
      m_out[0]   = m_isr;
    end
  endtask

  task automatic drive(input logic r, input logic i, input logic s, input logic m, input logic t);
    reset = r; interrupt = i; stallb_en = s; int_mask = m; ps_rti = t;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pulses, pcyc, fcyc;
    logic ri, rs, rm, rr, rx;

    m_drain = 0; m_vec = 1'b0; m_isr = 1'b0; m_pend = 1'b0; m_prev = 1'b0; m_out = '0;

    //               rst   int   stb   msk   rti   fdx vld ack isr
    tbl[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000_0_0_0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000_0_0_0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111_0_0_0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111_0_0_0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111_0_0_0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111_0_0_0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b111_0_0_0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b011_0_0_0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b011_0_0_0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100_1_1_0);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111_0_0_1);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b111_0_0_0);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b111_0_0_0);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b111_0_0_0);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b111_0_0_0);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111_0_0_0);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000_0_0_0);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111_0_0_0);

    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 18; k++) begin
      drive(tbl[k].rst, tbl[k].intr, tbl[k].stb, tbl[k].msk, tbl[k].rti);
      tick();
      check($sformatf("tbl[%0d]", k), 16'(outs), 16'(tbl[k].exp));
    end
    check("int_vec", int_vec, 16'h0010);

    // Stall held for three cycles inside FLUSH delays VECTOR by three.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check("stall_flush_entry", 16'(outs), 16'(6'b011000));
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("stall_frozen", 16'(outs), 16'(6'b000000));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulses = 0; pcyc = -1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_model", 16'(outs), 16'(m_out));
      if (ps_int_vec_ld) begin pulses++; pcyc = c; end
    end
    check("stall_pulse_count", 16'(pulses), 16'd1);
    check("stall_pulse_cycle", 16'(pcyc), 16'd1);

    // Edge during ISR is latched, not nested; serviced after RTI.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check("isr_no_nest", 16'(outs), 16'(6'b111001));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
    check("rti_exit", 16'(outs), 16'(6'b111000));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulses = 0; pcyc = -1; fcyc = -1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("reentry_model", 16'(outs), 16'(m_out));
      if (!fetch_en && fcyc < 0 && !ps_int_vec_ld) fcyc = c;
      if (ps_int_vec_ld) begin pulses++; pcyc = c; end
    end
    check("reentry_flush_cycle", 16'(fcyc), 16'd0);
    check("reentry_pulse_cycle", 16'(pcyc), 16'(PIPE_DEPTH - 1));
    check("reentry_pulse_count", 16'(pulses), 16'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();

    // Reset with the drain counter at 1 abandons the interrupt cleanly.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    tick();
    check("midflush_cnt1", 16'(outs), 16'(6'b011000));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check("midflush_reset", 16'(outs), 16'(6'b000000));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check("midflush_release", 16'(outs), 16'(6'b111000));
    for (int c = 0; c < 4; c++) begin
      tick();
      check("midflush_no_pending", 16'(outs), 16'(6'b111000));
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulses = 0; pcyc = -1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ps_int_vec_ld) begin pulses++; pcyc = c; end
    end
    check("post_reset_pulse_cycle", 16'(pcyc), 16'(PIPE_DEPTH - 1));
    check("post_reset_in_isr", 16'(outs), 16'(6'b111001));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
    check("post_reset_exit", 16'(outs), 16'(6'b111000));

    // Randomized traffic against the model.
    ri = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rx = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) ri = ~ri;
      rs = ($urandom_range(0, 4) != 0);
      rm = ($urandom_range(0, 5) == 0);
      rr = ($urandom_range(0, 7) == 0);
      drive(rx, ri, rs, rm, rr);
      tick();
      check("random", 16'(outs), 16'(m_out));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
Pipeline sequencer for the core. It produces the fetch, decode and execute stage enables in place of gated stage clocks, and applies external stall requests. It also sequences interrupt entry: drain the pipe, load the vector, track in-ISR status, and return on RTI. It sits between the core top-level inputs (interrupt, stallb_en) and the PS, memory, DAG and CU stage logic.

Parameters:
PIPE_DEPTH, 3, number of pipeline stages; the drain length is PIPE_DEPTH-1 cycles.
PMA_SIZE, 16, program memory address width.
INT_VECTOR, 16'h0010, program memory address of the interrupt service routine.

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  synchronous, active-high reset.
interrupt  input  1  external interrupt request, level, synchronous to clk.
stallb_en  input  1  active-low stall request; 0 freezes all stages.
int_mask  input  1  1 blocks acceptance of new interrupts.
ps_rti  input  1  one-cycle pulse from PS decode when an RTI instruction executes.
fetch_en  output  1  fetch stage enable (PC update, PM read).
dcd_en  output  1  decode stage enable.
exe_en  output  1  execute stage enable (CU, DAG writeback).
ps_int_vec_ld  output  1  one-cycle pulse: PS pushes the return PC and loads int_vec.
int_vec  output  PMA_SIZE  constant INT_VECTOR.
ps_int_ack  output  1  one-cycle pulse, coincident with ps_int_vec_ld.
in_isr  output  1  high while the ISR is executing.

Behaviour:
- Outputs are registered and change on the rising clk edge.
- Reset values: fetch_en=dcd_en=exe_en=0 in the reset cycle, then 1 on the first cycle after reset deasserts; all other outputs 0; state RUN; pending=0; drain counter=0.
- Edge detect: int_prev registers interrupt.
  - pending is set when interrupt=1, int_prev=0 and int_mask=0.
  - pending is cleared on entry to VECTOR.
  - A rising edge while pending=1 is absorbed; there is no counting.
- Stall: when stallb_en=0 in any state, all three enables are 0 in the next cycle.
  - State, drain counter and pending hold.
  - Exception: edge capture into pending continues during a stall.
  - When stallb_en returns to 1, the enables resume in the next cycle at their state values.
- State RUN:
  - Enables are 1/1/1.
  - If pending=1, in_isr=0 and stallb_en=1, go to FLUSH and load drain counter = PIPE_DEPTH-1.
- State FLUSH:
  - fetch_en=0; dcd_en=exe_en=1, so in-flight instructions complete and no new fetch occurs.
  - The counter decrements each unstalled cycle.
  - When the counter reaches 1 and the cycle is unstalled, go to VECTOR.
- State VECTOR (exactly one unstalled cycle):
  - ps_int_vec_ld=1 and ps_int_ack=1.
  - fetch_en=1, dcd_en=0, exe_en=0.
  - Next state is ISR.
  - If stalled, the pulse is deferred: it is not asserted while stallb_en=0 and is issued once on the first unstalled cycle.
- State ISR:
  - in_isr=1; enables are 1/1/1.
  - New edges latch into pending but are not serviced (no nesting).
  - ps_rti=1 moves the state to RUN with in_isr=0 in the next cycle.
  - If pending=1 then, re-entry to FLUSH starts one cycle after RUN is reached.
- ps_rti outside ISR is ignored.
- Simultaneous interrupt edge and ps_rti: the ISR exits and pending sets; the interrupt is serviced from RUN.
- int_mask rising after pending is set does not cancel the pending interrupt.
- Reset in any state, including mid-FLUSH or mid-VECTOR, returns to the reset values; no pulse is emitted.
- Drain counter width is clog2(PIPE_DEPTH). PIPE_DEPTH must be ≥2; this is checked by a static assertion.

Decomposition:
- Shared package pipe_seq_pkg holds:
  - the state encoding (RUN, FLUSH, VECTOR, ISR, 2-bit);
  - the default INT_VECTOR;
  - the enable-vector constants EN_ALL=3'b111, EN_DRAIN=3'b011, EN_VEC=3'b100, ordered {fetch, dcd, exe}.
- One sub-module, int_edge_latch, holds the edge detect, mask qualification and pending flag.
- The FSM and counter stay in the top module.

Test Plan:
- Reset for 2 cycles, release: enables 0 during reset and 1/1/1 on the cycle after release; all pulses 0; in_isr=0.
- Idle in RUN, interrupt rises at cycle 10 with int_mask=0:
  - FLUSH in cycles 12-13 with enables 0/1/1;
  - VECTOR at cycle 14 with ps_int_vec_ld=1, ps_int_ack=1, int_vec=16'h0010;
  - in_isr=1 from cycle 15.
- Hold stallb_en=0 for 3 cycles during FLUSH: enables 0/0/0 for 3 cycles; VECTOR is delayed by exactly 3 cycles; exactly one vec_ld pulse.
- Second interrupt edge during ISR, then ps_rti:
  - in_isr falls the cycle after ps_rti;
  - the FSM re-enters FLUSH one cycle after RUN is reached;
  - a second vec_ld pulse follows PIPE_DEPTH-1 cycles later.
- int_mask=1 during the interrupt edge: no pending, no FLUSH, enables stay 1/1/1; ps_rti pulses while in RUN have no effect.
- Assert reset mid-FLUSH (counter=1): the next cycle is state RUN with pending=0 and no vec_ld pulse; a later edge is serviced normally.
